// File: rtl/shift_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_stream_arbiter
// Purpose  : Shares one AXI-stream byte-shifter among NUM_PORTS streams with
//            packet-granular round-robin arbitration. The granted port's shift
//            amount is latched and held stable for the whole packet. Idle
//            flush beats follow each packet so the shifter can drain its
//            residual trailing beat before the shift value changes.
// Ports    : clk, reset_n      - clock, asynchronous active-low reset
//            s_data/s_valid/s_tkeep/s_tlast/s_ready - per-port slave streams
//            cfg_shift         - per-port byte shift amount
//            m_data/m_valid/m_tkeep/m_tlast/m_ready - master stream to shifter
//            m_shift_val       - registered shift value to the shifter
//            grant_id          - registered id of the granted port
//            busy              - high while a packet or its flush gap is active
//            pkt_done          - one-cycle pulse after a tlast beat is accepted
// Revision : 1.0 - initial release
// ============================================================================
module shift_stream_arbiter #(
   parameter int DATA_WIDTH = 512,
   parameter int NUM_PORTS  = 4,
   parameter int GAP_BEATS  = 1,
   parameter int SHIFT_W    = $clog2(DATA_WIDTH / 8),
   parameter int ID_W       = $clog2(NUM_PORTS)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_data,
   input  logic [NUM_PORTS-1:0]              s_valid,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
   input  logic [NUM_PORTS-1:0]              s_tlast,
   output logic [NUM_PORTS-1:0]              s_ready,
   input  logic [NUM_PORTS*SHIFT_W-1:0]      cfg_shift,
   output logic [DATA_WIDTH-1:0]             m_data,
   output logic                              m_valid,
   output logic [DATA_WIDTH/8-1:0]           m_tkeep,
   output logic                              m_tlast,
   input  logic                              m_ready,
   output logic [SHIFT_W-1:0]                m_shift_val,
   output logic [ID_W-1:0]                   grant_id,
   output logic                              busy,
   output logic                              pkt_done
);

   localparam int C_KEEP_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PKT  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t          r_state;
   logic [ID_W-1:0] r_rr_ptr;
   logic [3:0]      r_gap_cnt;

   logic            w_any;
   logic [ID_W-1:0] w_winner;
   logic [ID_W-1:0] w_cand;
   logic            w_last_acc;

   // Round-robin search starting one past the last winner. The loop walks
   // from the farthest offset to the nearest so the nearest requester wins.
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         w_cand = ID_W'((int'(r_rr_ptr) + i) % NUM_PORTS);
         if (s_valid[w_cand]) begin
            w_any    = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // Master side is a pure mux of the granted port while in PKT; it is
   // forced to zero otherwise so no partial packet can leak out.
   always_comb begin
      m_data  = '0;
      m_tkeep = '0;
      m_tlast = 1'b0;
      m_valid = 1'b0;
      s_ready = '0;
      if (r_state == ST_PKT) begin
         m_data            = s_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
         m_tkeep           = s_tkeep[int'(grant_id)*C_KEEP_W +: C_KEEP_W];
         m_tlast           = s_tlast[grant_id];
         m_valid           = s_valid[grant_id];
         s_ready[grant_id] = m_ready;
      end
   end

   assign w_last_acc = m_valid & m_ready & m_tlast;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= ID_W'(NUM_PORTS - 1);
         r_gap_cnt   <= 4'd0;
         m_shift_val <= '0;
         grant_id    <= '0;
         busy        <= 1'b0;
         pkt_done    <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  grant_id    <= w_winner;
                  r_rr_ptr    <= w_winner;
                  m_shift_val <= cfg_shift[int'(w_winner)*SHIFT_W +: SHIFT_W];
                  busy        <= 1'b1;
                  r_state     <= ST_PKT;
               end
            end
            ST_PKT: begin
               if (w_last_acc) begin
                  pkt_done <= 1'b1;
                  if (GAP_BEATS == 0) begin
                     busy    <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_gap_cnt <= 4'(GAP_BEATS);
                     r_state   <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               // The shifter pipeline only advances when it is ready, so a
               // flush beat only counts on those cycles.
               if (m_ready) begin
                  if (r_gap_cnt <= 4'd1) begin
                     r_gap_cnt <= 4'd0;
                     busy      <= 1'b0;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - 4'd1;
                  end
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_stream_arbiter
// Purpose  : Self-checking bench for shift_stream_arbiter. Two instances share
//            one stimulus: one with a single flush beat, one with none.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_stream_arbiter;

   localparam int DW = 128;
   localparam int NP = 4;
   localparam int KW = DW / 8;

   logic            clk;
   logic            reset_n;
   logic [NP*DW-1:0] s_data;
   logic [NP-1:0]   s_valid;
   logic [NP*KW-1:0] s_tkeep;
   logic [NP-1:0]   s_tlast;
   logic [NP*4-1:0] cfg_shift;
   logic            m_ready;

   logic [NP-1:0] s_ready1, s_ready0;
   logic [DW-1:0] m_data1, m_data0;
   logic          m_valid1, m_valid0;
   logic [KW-1:0] m_tkeep1, m_tkeep0;
   logic          m_tlast1, m_tlast0;
   logic [3:0]    m_shift_val1, m_shift_val0;
   logic [1:0]    grant_id1, grant_id0;
   logic          busy1, busy0;
   logic          pkt_done1, pkt_done0;

   shift_stream_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .GAP_BEATS(1)) dut (
      .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_ready(s_ready1),
      .cfg_shift(cfg_shift), .m_data(m_data1), .m_valid(m_valid1),
      .m_tkeep(m_tkeep1), .m_tlast(m_tlast1), .m_ready(m_ready),
      .m_shift_val(m_shift_val1), .grant_id(grant_id1), .busy(busy1),
      .pkt_done(pkt_done1)
   );

   shift_stream_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .GAP_BEATS(0)) dut_nogap (
      .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_ready(s_ready0),
      .cfg_shift(cfg_shift), .m_data(m_data0), .m_valid(m_valid0),
      .m_tkeep(m_tkeep0), .m_tlast(m_tlast0), .m_ready(m_ready),
      .m_shift_val(m_shift_val0), .grant_id(grant_id0), .busy(busy0),
      .pkt_done(pkt_done0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rst;    // pulse reset before applying this vector
      bit         use0;   // check the no-gap instance
      logic [3:0] vld;
      logic [3:0] lst;
      logic       rdy;
      logic [15:0] cfg;
      logic       mv;
      logic       ml;
      logic [1:0] gid;
      logic [3:0] sv;
      logic       bsy;
      logic       done;
      logic [3:0] srdy;
      int         src;    // port expected on m_data/m_tkeep, -1 for none
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(bit r, bit u, logic [3:0] vld, logic [3:0] lst,
                               logic rdy, logic [15:0] cfg, logic mv, logic ml,
                               logic [1:0] gid, logic [3:0] sv, logic bsy,
                               logic done, logic [3:0] srdy, int src);
      vec_t v;
      v.rst = r; v.use0 = u; v.vld = vld; v.lst = lst; v.rdy = rdy; v.cfg = cfg;
      v.mv = mv; v.ml = ml; v.gid = gid; v.sv = sv; v.bsy = bsy; v.done = done;
      v.srdy = srdy; v.src = src;
      return v;
   endfunction

   function automatic logic [DW-1:0] pdata(int p, int k);
      logic [31:0] w;
      w = (32'(p) << 28) | 32'(k);
      return {4{w}};
   endfunction

   function automatic logic [KW-1:0] pkeep(int p);
      return 16'hFFFF >> p;
   endfunction

   task automatic drive_data(int k);
      for (int p = 0; p < NP; p++) begin
         s_data[p*DW +: DW]  = pdata(p, k);
         s_tkeep[p*KW +: KW] = pkeep(p);
      end
   endtask

   task automatic chk(string nm, int k, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, k, act, exp);
      end
   endtask

   task automatic check_vec(vec_t v, int k);
      logic [DW-1:0] ed;
      logic [KW-1:0] ek;
      ed = (v.src < 0) ? '0 : pdata(v.src, k);
      ek = (v.src < 0) ? '0 : pkeep(v.src);
      if (v.use0) begin
         chk("m_valid", k, DW'(m_valid0), DW'(v.mv));
         chk("m_tlast", k, DW'(m_tlast0), DW'(v.ml));
         chk("grant_id", k, DW'(grant_id0), DW'(v.gid));
         chk("m_shift_val", k, DW'(m_shift_val0), DW'(v.sv));
         chk("busy", k, DW'(busy0), DW'(v.bsy));
         chk("pkt_done", k, DW'(pkt_done0), DW'(v.done));
         chk("s_ready", k, DW'(s_ready0), DW'(v.srdy));
         chk("m_data", k, m_data0, ed);
         chk("m_tkeep", k, DW'(m_tkeep0), DW'(ek));
      end else begin
         chk("m_valid", k, DW'(m_valid1), DW'(v.mv));
         chk("m_tlast", k, DW'(m_tlast1), DW'(v.ml));
         chk("grant_id", k, DW'(grant_id1), DW'(v.gid));
         chk("m_shift_val", k, DW'(m_shift_val1), DW'(v.sv));
         chk("busy", k, DW'(busy1), DW'(v.bsy));
         chk("pkt_done", k, DW'(pkt_done1), DW'(v.done));
         chk("s_ready", k, DW'(s_ready1), DW'(v.srdy));
         chk("m_data", k, m_data1, ed);
         chk("m_tkeep", k, DW'(m_tkeep1), DW'(ek));
      end
   endtask

   initial begin
      logic [15:0] c2;
      int          g, pg;
      logic [3:0]  s, ps;

      reset_n   = 1'b0;
      s_data    = '0;
      s_valid   = '0;
      s_tkeep   = '0;
      s_tlast   = '0;
      cfg_shift = '0;
      m_ready   = 1'b0;

      // Single 3-beat packet on port 0, shift 5, one flush beat.
      vecs.push_back(mk(1,0,4'b0001,4'b0000,1,16'h0005, 0,0,0,0,0,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0000,1,16'h0005, 1,0,0,5,1,0,4'b0001, 0));
      vecs.push_back(mk(0,0,4'b0001,4'b0000,1,16'h0005, 1,0,0,5,1,0,4'b0001, 0));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,1,16'h0005, 1,1,0,5,1,0,4'b0001, 0));
      vecs.push_back(mk(0,0,4'b0000,4'b0000,1,16'h0005, 0,0,0,5,1,1,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0000,4'b0000,1,16'h0005, 0,0,0,5,0,0,4'b0000,-1));

      // All ports valid, 2-beat packets: grants 0,1,2,3,0,1.
      c2 = 16'h3751;
      for (int k = 0; k < 6; k++) begin
         g  = k % 4;
         pg = (k == 0) ? 0 : (k - 1) % 4;
         s  = c2[g*4 +: 4];
         ps = (k == 0) ? 4'd0 : c2[pg*4 +: 4];
         vecs.push_back(mk(k == 0,0,4'b1111,4'b0000,1,c2, 0,0,2'(pg),ps,0,0,4'b0000,-1));
         vecs.push_back(mk(0,0,4'b1111,4'b0000,1,c2, 1,0,2'(g),s,1,0,4'(1 << g), g));
         vecs.push_back(mk(0,0,4'b1111,4'b1111,1,c2, 1,1,2'(g),s,1,0,4'(1 << g), g));
         vecs.push_back(mk(0,0,4'b1111,4'b0000,1,c2, 0,0,2'(g),s,1,1,4'b0000,-1));
      end

      // Backpressure for 4 cycles inside the gap while port 0 waits.
      vecs.push_back(mk(1,0,4'b0100,4'b0100,1,16'h0701, 0,0,0,0,0,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0100,4'b0100,1,16'h0701, 1,1,2,7,1,0,4'b0100, 2));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,0,16'h0701, 0,0,2,7,1,1,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,0,16'h0701, 0,0,2,7,1,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,0,16'h0701, 0,0,2,7,1,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,0,16'h0701, 0,0,2,7,1,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,1,16'h0701, 0,0,2,7,1,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,1,16'h0701, 0,0,2,7,0,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0001,4'b0001,1,16'h0701, 1,1,0,1,1,0,4'b0001, 0));
      vecs.push_back(mk(0,0,4'b0000,4'b0000,1,16'h0701, 0,0,0,1,1,1,4'b0000,-1));

      // Port 1 shift changes 5 -> 9 mid-packet; only the next grant sees 9.
      vecs.push_back(mk(1,0,4'b0010,4'b0000,1,16'h0050, 0,0,0,0,0,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0010,4'b0000,1,16'h0090, 1,0,1,5,1,0,4'b0010, 1));
      vecs.push_back(mk(0,0,4'b0010,4'b0010,1,16'h0090, 1,1,1,5,1,0,4'b0010, 1));
      vecs.push_back(mk(0,0,4'b0000,4'b0000,1,16'h0090, 0,0,1,5,1,1,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0010,4'b0000,1,16'h0090, 0,0,1,5,0,0,4'b0000,-1));
      vecs.push_back(mk(0,0,4'b0010,4'b0010,1,16'h0090, 1,1,1,9,1,0,4'b0010, 1));

      // No-gap instance: single-beat packets on ports 0 and 3 alternate.
      vecs.push_back(mk(1,1,4'b1001,4'b1001,1,16'h3001, 0,0,0,0,0,0,4'b0000,-1));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 1,1,0,1,1,0,4'b0001, 0));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 0,0,0,1,0,1,4'b0000,-1));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 1,1,3,3,1,0,4'b1000, 3));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 0,0,3,3,0,1,4'b0000,-1));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 1,1,0,1,1,0,4'b0001, 0));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 0,0,0,1,0,1,4'b0000,-1));
      vecs.push_back(mk(0,1,4'b1001,4'b1001,1,16'h3001, 1,1,3,3,1,0,4'b1000, 3));

      foreach (vecs[k]) begin
         @(posedge clk);
         #1;
         if (vecs[k].rst) begin
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
         end
         s_valid   = vecs[k].vld;
         s_tlast   = vecs[k].lst;
         m_ready   = vecs[k].rdy;
         cfg_shift = vecs[k].cfg;
         drive_data(k);
         #3;
         check_vec(vecs[k], k);
      end

      // Reset asserted during beat 2 of a 4-beat packet on port 2.
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      s_valid   = 4'b0100;
      s_tlast   = 4'b0000;
      m_ready   = 1'b1;
      cfg_shift = 16'h0702;
      drive_data(100);
      @(posedge clk);
      #1;
      chk("rst_beat1_valid", 100, DW'(m_valid1), DW'(1'b1));
      @(posedge clk);
      #1;
      chk("rst_beat2_grant", 101, DW'(grant_id1), DW'(2'd2));
      chk("rst_beat2_shift", 101, DW'(m_shift_val1), DW'(4'd7));
      reset_n = 1'b0;
      #1;
      chk("rst_m_valid", 102, DW'(m_valid1), DW'(1'b0));
      chk("rst_s_ready", 102, DW'(s_ready1), DW'(4'b0000));
      chk("rst_shift", 102, DW'(m_shift_val1), DW'(4'd0));
      chk("rst_grant", 102, DW'(grant_id1), DW'(2'd0));
      chk("rst_busy", 102, DW'(busy1), DW'(1'b0));
      chk("rst_m_data", 102, m_data1, '0);
      @(posedge clk);
      #1;
      s_valid = 4'b0101;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_grant", 103, DW'(grant_id1), DW'(2'd0));
      chk("post_rst_shift", 103, DW'(m_shift_val1), DW'(4'd2));
      chk("post_rst_valid", 103, DW'(m_valid1), DW'(1'b1));
      chk("post_rst_ready", 103, DW'(s_ready1), DW'(4'b0001));
      chk("post_rst_data", 103, m_data1, pdata(0, 100));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
